// File: rtl/adc_capture_buf_if.sv
// Bus between the ADC front end / readout logic and adc_capture_buf:
// capture control, sample stream, read port and status.
interface adc_capture_buf_if #(
    parameter int DATA_W = 12,
    parameter int ADDR_W = 10,
    parameter int DEC_W  = 8
);
    logic              wr_adc;
    logic              stop;
    logic              cont;
    logic [DEC_W-1:0]  decim;
    logic              sample_vld;
    logic [DATA_W-1:0] indata;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] data;
    logic              rd_vld;
    logic              busy;
    logic              wr_end;
    logic              wrapped;
    logic [ADDR_W-1:0] last_addr;

    modport master (
        output wr_adc, stop, cont, decim, sample_vld, indata, rd_en, rd_addr,
        input  data, rd_vld, busy, wr_end, wrapped, last_addr
    );

    modport slave (
        input  wr_adc, stop, cont, decim, sample_vld, indata, rd_en, rd_addr,
        output data, rd_vld, busy, wr_end, wrapped, last_addr
    );
endinterface

// File: rtl/adc_capture_buf.sv
// Capture buffer: records CAP_LEN qualified ADC samples (optionally decimated,
// single-shot or ring) into RAM and drains them through a registered read port.
//
// state   | meaning
// IDLE    | nothing captured since reset
// CAPTURE | writing qualified samples, read port blocked
// DONE    | capture finished, buffer readable
module adc_capture_buf #(
    parameter int DATA_W  = 12,
    parameter int ADDR_W  = 10,
    parameter int CAP_LEN = 256,
    parameter int DEC_W   = 8
) (
    input logic              clk,
    input logic              rstn,
    adc_capture_buf_if.slave bus
);
    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CAP_LEN - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_addr;
    logic [DEC_W-1:0]  dec_cnt;
    logic [DEC_W-1:0]  decim_q;
    logic              cont_q;
    logic              start;
    logic              accept;
    logic              at_end;
    logic              rd_fire;

    // A start (or restart) takes priority over stop and drops any sample that cycle.
    always_comb begin
        start     = bus.wr_adc;
        accept    = (state == CAPTURE) && !start && bus.sample_vld && (dec_cnt == '0);
        at_end    = (wr_addr == LAST_ADDR);
        rd_fire   = bus.rd_en && (state != CAPTURE);
        state_nxt = state;
        if (start) begin
            state_nxt = CAPTURE;
        end else if (state == CAPTURE) begin
            if (bus.stop || (accept && at_end && !cont_q)) begin
                state_nxt = DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_addr       <= '0;
            dec_cnt       <= '0;
            decim_q       <= '0;
            cont_q        <= 1'b0;
            bus.wrapped   <= 1'b0;
            bus.last_addr <= '0;
        end else if (start) begin
            wr_addr     <= '0;
            dec_cnt     <= '0;
            decim_q     <= bus.decim;
            cont_q      <= bus.cont;
            bus.wrapped <= 1'b0;
        end else if (state == CAPTURE) begin
            if (bus.sample_vld) begin
                if (dec_cnt == '0) begin
                    dec_cnt <= decim_q;
                end else begin
                    dec_cnt <= dec_cnt - 1'b1;
                end
            end
            if (accept) begin
                bus.last_addr <= wr_addr;
                if (at_end) begin
                    wr_addr <= '0;
                    if (cont_q) begin
                        bus.wrapped <= 1'b1;
                    end
                end else begin
                    wr_addr <= wr_addr + 1'b1;
                end
            end
        end
    end

    // RAM is deliberately left out of reset so it maps onto block memory.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_addr] <= bus.indata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.data   <= '0;
            bus.rd_vld <= 1'b0;
        end else begin
            bus.rd_vld <= rd_fire;
            if (rd_fire) begin
                bus.data <= mem[bus.rd_addr];
            end
        end
    end

    assign bus.busy   = (state == CAPTURE);
    assign bus.wr_end = (state == DONE);
endmodule
